// File: rtl/reg_file_sb.sv
// reg_file_sb: 32-entry general-purpose register file with a pending-write scoreboard.
// Supplies the A/B operand latches through two combinational read ports. The writeback
// stage drives the single write port. The scoreboard tracks issued-but-not-written
// destinations and flags read-after-write (hazard) and write-after-write (waw) conflicts.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   ra1, ra2          read addresses (A and B operands)
//   rd1, rd2          combinational read data, with same-cycle writeback bypass
//   we, wa, wd        writeback write enable, address and data
//   issue_valid       an instruction with a register destination issues this cycle
//   issue_dst         destination register of the issuing instruction
//   hazard            ra1/ra2 names a register whose write is still outstanding (comb)
//   waw               issue_dst is already pending (comb)
//   busy              at least one pending bit is set (from registered state)
module reg_file_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_dst,
   output logic              hazard,
   output logic              waw,
   output logic              busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;

   logic wr_en;
   logic set_en;
   logic wr_hit1;
   logic wr_hit2;
   logic wr_hit_dst;
   logic h1;
   logic h2;

   // Writes and issues to register 0 are discarded.
   assign wr_en  = we && (wa != '0);
   assign set_en = issue_valid && (issue_dst != '0);

   // A writeback in the current cycle to the same address resolves the conflict.
   assign wr_hit1    = we && (wa == ra1);
   assign wr_hit2    = we && (wa == ra2);
   assign wr_hit_dst = we && (wa == issue_dst);

   // Read ports: zero register, then bypass of the in-flight write, then storage.
   always_comb begin
      rd1 = mem[ra1];
      if (ra1 == '0)
         rd1 = '0;
      else if (wr_hit1)
         rd1 = wd;

      rd2 = mem[ra2];
      if (ra2 == '0)
         rd2 = '0;
      else if (wr_hit2)
         rd2 = wd;
   end

   // Scoreboard next state: the clear is applied first so that a same-address set wins.
   always_comb begin
      pend_d = pend_q;
      if (wr_en)
         pend_d[wa] = 1'b0;
      if (set_en)
         pend_d[issue_dst] = 1'b1;
      pend_d[0] = 1'b0;
   end

   assign h1     = (ra1 != '0) && pend_q[ra1] && !wr_hit1;
   assign h2     = (ra2 != '0) && pend_q[ra2] && !wr_hit2;
   assign hazard = h1 || h2;
   assign waw    = set_en && pend_q[issue_dst] && !wr_hit_dst;
   assign busy   = |pend_q[DEPTH-1:1];

   // Storage and scoreboard state; reset takes precedence over writeback and issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         pend_q <= '0;
      end else begin
         if (wr_en)
            mem[wa] <= wd;
         pend_q <= pend_d;
      end
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 32-entry general-purpose register file with an integrated pending-write scoreboard.
- It is the source side of the operand latches. Its two read ports drive the A and B operand registers, and its write port is fed by the writeback stage.
- The scoreboard tracks destinations that have been issued but not yet written back. It flags read-after-write hazards so control can stall before the operand latches capture stale data.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width. Depth is 2**ADDR_W, so 32 entries.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- ra1  in  ADDR_W  read address, port 1 (A operand).
- ra2  in  ADDR_W  read address, port 2 (B operand).
- rd1  out  DATA_W  read data, port 1; combinational.
- rd2  out  DATA_W  read data, port 2; combinational.
- we  in  1  writeback write enable.
- wa  in  ADDR_W  writeback address.
- wd  in  DATA_W  writeback data.
- issue_valid  in  1  an instruction with a register destination is being issued this cycle.
- issue_dst  in  ADDR_W  destination register of the issuing instruction.
- hazard  out  1  ra1 or ra2 names a register with an outstanding write; combinational.
- waw  out  1  issue_dst is already pending; combinational.
- busy  out  1  at least one pending bit is set; registered-state derived.

Behaviour:
Reset
- Synchronous: at a rising clk with reset=1, all 32 entries go to 0 and all pending bits go to 0.
- reset overrides we and issue_valid in that cycle.
- After reset, rd1 = rd2 = 0 for any address, and hazard = waw = busy = 0.
- Reset asserted mid-operation discards all outstanding pending bits; there is no partial state.

Register 0
- Always reads 0.
- Writes to address 0 are ignored and never set or clear a pending bit.
- Address 0 never produces hazard or waw.

Write
- At a rising clk with we=1 and wa!=0, mem[wa] <= wd. Write latency is one edge.

Read
- Combinational: rdN = 0 if raN==0.
- Otherwise rdN = wd if we && wa==raN (write-through bypass, the same-cycle value).
- Otherwise rdN = mem[raN].
- Both ports may read the same address; both receive the identical value.

Scoreboard
- pend[31:1] is a register; pend[0] is tied to 0.
- Set: issue_valid && issue_dst!=0 sets pend[issue_dst] at the next edge.
- Clear: we && wa!=0 clears pend[wa] at the next edge.
- Simultaneous set and clear of the same address: the set wins (the new producer supersedes the completing one).
- Set and clear on different addresses in the same cycle both take effect.
- Clear of a non-pending register is harmless (writes with no issue are legal).

hazard
- h1 = ra1!=0 && pend[ra1] && !(we && wa==ra1).
- h2 is the same expression with ra2.
- hazard = h1 | h2. A writeback in the current cycle resolves the hazard through the bypass.

waw
- waw = issue_valid && issue_dst!=0 && pend[issue_dst] && !(we && wa==issue_dst).

Other rules
- busy = OR of pend[31:1].
- The block does not gate issue_valid on hazard or waw; stalling is the controller's job.
- An issue accepted while hazard=1 still updates pend.
- No arithmetic and no wrap. Addresses are fully decoded, since depth = 2**ADDR_W.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> every rd1/rd2 = 0; hazard = waw = busy = 0.
2. Write we=1, wa=5, wd=0xDEADBEEF with ra1=5 in the same cycle -> rd1 = 0xDEADBEEF combinationally (bypass). The next cycle with we=0 still gives rd1 = 0xDEADBEEF. Write wa=0, wd=0x1234 -> rd1 for ra1=0 stays 0.
3. Issue issue_dst=7; the next cycle ra2=7 -> hazard=1, busy=1. Writeback wa=7, wd=0x55 in the same cycle as ra2=7 -> hazard=0 and rd2=0x55. The following cycle pend[7]=0 and busy=0.
4. Pend[9] is set; in one cycle issue_dst=9 and we=1, wa=9 -> after the edge pend[9] stays 1 (set wins) and ra1=9 gives hazard=1. In that same cycle waw=0, because the completing write masks it.
5. Issue issue_dst=3 twice in consecutive cycles with no writeback -> waw=1 on the second issue. Issue issue_dst=0 -> pend unchanged and waw=0.
6. Set pend[4], pend[12], pend[31], then assert reset for one cycle with we=1, wa=4, wd=0xFF -> busy=0, all pending bits clear, and mem[4]=0 (reset overrides the write).
